// File: rtl/mem_stage.sv
// mem_stage: RV32 MEM stage. Issues loads/stores to the data cache or the AES
// MMIO slave over a valid/ready handshake, formats store lanes, extracts and
// extends load data, and owns the MEM/WB pipeline register.
module mem_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] AES_BASE = 32'h4000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] alu_mem_i,
  input  logic [XLEN-1:0] rs2_mem_i,
  input  logic [XLEN-1:0] pc4_mem_i,
  input  logic            MemRW_mem_i,
  input  logic [1:0]      WBSel_mem_i,
  input  logic            RegWEn_mem_i,
  input  logic [4:0]      rsW_mem_i,
  input  logic [31:0]     inst_mem_i,
  input  logic            Valid_cpu2cache_mem_i,
  input  logic            Valid_cpu2aes_mem_i,
  input  logic            csr_we_mem_i,
  input  logic [31:0]     csr_waddr_mem_i,
  input  logic [XLEN-1:0] csr_rdata_mem_i,
  input  logic            enable_i,
  input  logic            reset_i,
  output logic            dmem_valid_o,
  output logic            aes_valid_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_be_o,
  output logic            mem_we_o,
  input  logic            dmem_ready_i,
  input  logic            aes_ready_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic [XLEN-1:0] aes_rdata_i,
  output logic            stall_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] data_wb_o,
  output logic            RegWEn_wb_o,
  output logic [4:0]      rsW_wb_o,
  output logic [31:0]     inst_wb_o,
  output logic            csr_we_wb_o,
  output logic [31:0]     csr_waddr_wb_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      funct3;
  logic            access, misaligned, use_aes;
  logic            req, sel_ready, complete, stall, advance;
  logic [XLEN-1:0] sel_rdata, rdata_q, load_src, load_data, wb_data, wdata;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [3:0]      be;

  // The AES slave decodes word offsets from this base.
  if (AES_BASE[1:0] != 2'b00) begin : g_aes_base_check
    $error("mem_stage: AES_BASE must be word aligned");
  end

  assign funct3     = inst_mem_i[14:12];
  assign access     = Valid_cpu2cache_mem_i | Valid_cpu2aes_mem_i;
  assign misaligned = access &
                      (((funct3[1:0] == 2'b01) & alu_mem_i[0]) |
                       ((funct3[1:0] == 2'b10) & (alu_mem_i[1:0] != 2'b00)));
  assign use_aes    = Valid_cpu2aes_mem_i & ~Valid_cpu2cache_mem_i;

  assign sel_ready  = use_aes ? aes_ready_i : dmem_ready_i;
  assign sel_rdata  = use_aes ? aes_rdata_i : dmem_rdata_i;

  // A request is raised once from IDLE and then held in BUSY until accepted;
  // HOLD never re-issues the already completed access.
  assign req      = ((state_q == IDLE) & access & ~misaligned) | (state_q == BUSY);
  assign complete = req & sel_ready;
  assign stall    = req & ~sel_ready;
  assign advance  = enable_i & ~stall;

  // Next-state logic for the access handshake.
  always_comb begin
    // NOTE: every always_comb variable gets a default first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = !complete ? BUSY : (enable_i ? IDLE : HOLD);
      BUSY: if (complete) state_d = enable_i ? IDLE : HOLD;
      HOLD: if (enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store lane formatting: replicate the datum so any byte lane carries it.
  always_comb begin
    be    = 4'b1111;
    wdata = rs2_mem_i;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << alu_mem_i[1:0];
        wdata = {4{rs2_mem_i[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << alu_mem_i[1:0];
        wdata = {2{rs2_mem_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load data comes from the live bus on completion, or the capture in HOLD.
  assign load_src  = (state_q == HOLD) ? rdata_q : sel_rdata;
  assign byte_lane = load_src[{alu_mem_i[1:0], 3'b000} +: 8];
  assign half_lane = load_src[{alu_mem_i[1], 4'b0000} +: 16];

  // Load extraction with sign (funct3[2]=0) or zero (funct3[2]=1) extension.
  always_comb begin
    load_data = load_src;
    case (funct3[1:0])
      2'b00:   load_data = {{(XLEN-8){~funct3[2] & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{(XLEN-16){~funct3[2] & half_lane[15]}}, half_lane};
      default: ;
    endcase
  end

  // Writeback source select.
  always_comb begin
    wb_data = load_data;
    case (WBSel_mem_i)
      2'd1:    wb_data = alu_mem_i;
      2'd2:    wb_data = pc4_mem_i;
      2'd3:    wb_data = csr_rdata_mem_i;
      default: wb_data = load_data;
    endcase
  end

  // NOTE: combinational outputs are gated by rst_ni so nothing is driven while
  // reset is asserted, even if the EX/MEM register still presents an access.
  assign dmem_valid_o = rst_ni & req & ~use_aes;
  assign aes_valid_o  = rst_ni & req & use_aes;
  assign mem_we_o     = rst_ni & req & MemRW_mem_i;
  assign mem_addr_o   = rst_ni ? {alu_mem_i[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata_o  = rst_ni ? wdata : '0;
  assign mem_be_o     = rst_ni ? be : 4'b0000;
  assign stall_o      = rst_ni & stall;
  // Fires only on the enabled cycle; the instruction leaves MEM right after.
  assign misalign_o   = rst_ni & (state_q == IDLE) & misaligned & enable_i;

  // FSM state and captured read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (complete) rdata_q <= sel_rdata;
    end
  end

  // MEM/WB pipeline register with synchronous flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_wb_o      <= '0;
      RegWEn_wb_o    <= 1'b0;
      rsW_wb_o       <= '0;
      inst_wb_o      <= '0;
      csr_we_wb_o    <= 1'b0;
      csr_waddr_wb_o <= '0;
    end else if (advance) begin
      if (reset_i) begin
        data_wb_o      <= '0;
        RegWEn_wb_o    <= 1'b0;
        rsW_wb_o       <= '0;
        inst_wb_o      <= '0;
        csr_we_wb_o    <= 1'b0;
        csr_waddr_wb_o <= '0;
      end else begin
        data_wb_o      <= wb_data;
        RegWEn_wb_o    <= RegWEn_mem_i & ~misaligned;
        rsW_wb_o       <= rsW_mem_i;
        inst_wb_o      <= inst_mem_i;
        csr_we_wb_o    <= csr_we_mem_i;
        csr_waddr_wb_o <= csr_waddr_mem_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scenario tasks plus randomized accesses checked against a
// behavioural model of the memory stage rules.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] alu_mem_i, rs2_mem_i, pc4_mem_i;
  logic        MemRW_mem_i;
  logic [1:0]  WBSel_mem_i;
  logic        RegWEn_mem_i;
  logic [4:0]  rsW_mem_i;
  logic [31:0] inst_mem_i;
  logic        Valid_cpu2cache_mem_i, Valid_cpu2aes_mem_i, csr_we_mem_i;
  logic [31:0] csr_waddr_mem_i, csr_rdata_mem_i;
  logic        enable_i, reset_i;
  logic        dmem_valid_o, aes_valid_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_we_o;
  logic        dmem_ready_i, aes_ready_i;
  logic [31:0] dmem_rdata_i, aes_rdata_i;
  logic        stall_o, misalign_o;
  logic [31:0] data_wb_o;
  logic        RegWEn_wb_o;
  logic [4:0]  rsW_wb_o;
  logic [31:0] inst_wb_o;
  logic        csr_we_wb_o;
  logic [31:0] csr_waddr_wb_o;
  logic [175:0] all_outs;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_mem_i(alu_mem_i), .rs2_mem_i(rs2_mem_i), .pc4_mem_i(pc4_mem_i),
    .MemRW_mem_i(MemRW_mem_i), .WBSel_mem_i(WBSel_mem_i), .RegWEn_mem_i(RegWEn_mem_i),
    .rsW_mem_i(rsW_mem_i), .inst_mem_i(inst_mem_i),
    .Valid_cpu2cache_mem_i(Valid_cpu2cache_mem_i), .Valid_cpu2aes_mem_i(Valid_cpu2aes_mem_i),
    .csr_we_mem_i(csr_we_mem_i), .csr_waddr_mem_i(csr_waddr_mem_i), .csr_rdata_mem_i(csr_rdata_mem_i),
    .enable_i(enable_i), .reset_i(reset_i),
    .dmem_valid_o(dmem_valid_o), .aes_valid_o(aes_valid_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_we_o(mem_we_o),
    .dmem_ready_i(dmem_ready_i), .aes_ready_i(aes_ready_i),
    .dmem_rdata_i(dmem_rdata_i), .aes_rdata_i(aes_rdata_i),
    .stall_o(stall_o), .misalign_o(misalign_o), .data_wb_o(data_wb_o),
    .RegWEn_wb_o(RegWEn_wb_o), .rsW_wb_o(rsW_wb_o), .inst_wb_o(inst_wb_o),
    .csr_we_wb_o(csr_we_wb_o), .csr_waddr_wb_o(csr_waddr_wb_o)
  );

  assign all_outs = {dmem_valid_o, aes_valid_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o,
                     stall_o, misalign_o, data_wb_o, RegWEn_wb_o, rsW_wb_o, inst_wb_o,
                     csr_we_wb_o, csr_waddr_wb_o};

  always #5 clk_i = ~clk_i;

  // ---------------- reference model (access-size arithmetic) ----------------
  function automatic bit f_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = 1 << f3[1:0];
    return (int'(a[1:0]) % size) != 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << f3[1:0];
    if (n >= 4) return 4'hF;
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'h0000_00FF) * 32'h0101_0101;
      2'b01:   return (d & 32'h0000_FFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    int bits, off;
    logic [31:0] mask, v;
    bits = 8 << f3[1:0];
    if (bits >= 32) return d;
    off  = (bits == 8) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
    mask = (32'd1 << bits) - 32'd1;
    v    = (d >> off) & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    Valid_cpu2cache_mem_i = 1'b0;
    Valid_cpu2aes_mem_i   = 1'b0;
    MemRW_mem_i  = 1'b0;
    dmem_ready_i = 1'b0;
    aes_ready_i  = 1'b0;
    enable_i     = 1'b1;
    reset_i      = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [2:0] f3, input bit aes);
    alu_mem_i = addr;
    inst_mem_i = $urandom();
    inst_mem_i[14:12] = f3;
    MemRW_mem_i = 1'b0;
    WBSel_mem_i = 2'd0;
    RegWEn_mem_i = 1'b1;
    rsW_mem_i = 5'd7;
    Valid_cpu2cache_mem_i = !aes;
    Valid_cpu2aes_mem_i = aes;
  endtask

  // One access: the selected target answers on cycle 'lat'; the other target
  // is always ready with junk so a wrong target selection shows up.
  task automatic do_access(input bit store, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdat, input bit aes, input int lat,
                           input logic [31:0] rdat, input logic [1:0] wbsel, output int stalls);
    bit mis, regwen;
    int last;
    logic [36:0] exp_bus, got_bus;
    logic [31:0] exp_wb;
    logic [70:0] exp_reg, got_reg;
    regwen = 1'($urandom());
    alu_mem_i = addr; rs2_mem_i = wdat; pc4_mem_i = $urandom();
    MemRW_mem_i = store; WBSel_mem_i = wbsel; RegWEn_mem_i = regwen;
    rsW_mem_i = 5'($urandom()); inst_mem_i = $urandom(); inst_mem_i[14:12] = f3;
    Valid_cpu2cache_mem_i = !aes; Valid_cpu2aes_mem_i = aes;
    csr_we_mem_i = 1'($urandom()); csr_waddr_mem_i = $urandom(); csr_rdata_mem_i = $urandom();
    enable_i = 1'b1; reset_i = 1'b0;
    mis = f_misaligned(f3, addr);
    stalls = 0;
    last = mis ? 0 : lat;
    for (int cyc = 0; cyc <= last; cyc++) begin
      if (aes) begin
        aes_ready_i = (cyc == lat); aes_rdata_i = (cyc == lat) ? rdat : ~rdat;
        dmem_ready_i = 1'b1; dmem_rdata_i = $urandom();
      end else begin
        dmem_ready_i = (cyc == lat); dmem_rdata_i = (cyc == lat) ? rdat : ~rdat;
        aes_ready_i = 1'b1; aes_rdata_i = $urandom();
      end
      #3;
      if (mis) begin
        checks++;
        if ({dmem_valid_o, aes_valid_o, mem_we_o, stall_o, misalign_o} !== 5'b00001) begin
          errors++;
          $display("FAIL misaligned_req addr=%h: got v/a/we/st/mis=%b want 00001", addr,
                   {dmem_valid_o, aes_valid_o, mem_we_o, stall_o, misalign_o});
        end
      end else begin
        exp_bus = {!aes, aes, addr & ~32'h3, store, cyc != lat, 1'b0};
        got_bus = {dmem_valid_o, aes_valid_o, mem_addr_o, mem_we_o, stall_o, misalign_o};
        checks++;
        if (got_bus !== exp_bus) begin
          errors++;
          $display("FAIL request_bus addr=%h cyc=%0d: got %h want %h", addr, cyc, got_bus, exp_bus);
        end
        if (store) begin
          checks++;
          if ({mem_be_o, mem_wdata_o} !== {f_be(f3, addr), f_wdata(f3, wdat)}) begin
            errors++;
            $display("FAIL store_lanes addr=%h f3=%0d: got be=%b wdata=%h want be=%b wdata=%h",
                     addr, f3, mem_be_o, mem_wdata_o, f_be(f3, addr), f_wdata(f3, wdat));
          end
        end
        if (stall_o) stalls++;
      end
      step();
    end
    case (wbsel)
      2'd0:    exp_wb = f_load(f3, addr, rdat);
      2'd1:    exp_wb = addr;
      2'd2:    exp_wb = pc4_mem_i;
      default: exp_wb = csr_rdata_mem_i;
    endcase
    if (!(mis && wbsel == 2'd0)) begin
      checks++;
      if (data_wb_o !== exp_wb) begin
        errors++;
        $display("FAIL data_wb addr=%h f3=%0d wbsel=%0d: got %h want %h", addr, f3, wbsel,
                 data_wb_o, exp_wb);
      end
    end
    exp_reg = {regwen & !mis, rsW_mem_i, inst_mem_i, csr_we_mem_i, csr_waddr_mem_i};
    got_reg = {RegWEn_wb_o, rsW_wb_o, inst_wb_o, csr_we_wb_o, csr_waddr_wb_o};
    checks++;
    if (got_reg !== exp_reg) begin
      errors++;
      $display("FAIL memwb_copy addr=%h: got %h want %h", addr, got_reg, exp_reg);
    end
    drive_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    pc4_mem_i = 32'h4; rs2_mem_i = 32'h1111_2222; csr_we_mem_i = 1'b1;
    csr_waddr_mem_i = 32'h300; csr_rdata_mem_i = 32'h55; reset_i = 1'b0; enable_i = 1'b1;
    set_load(32'h100, 3'b010, 1'b0);
    dmem_ready_i = 1'b0; aes_ready_i = 1'b0; dmem_rdata_i = '0; aes_rdata_i = '0;
    #2;
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    step();
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_outputs_after_edge: got %h want 0", all_outs);
    end
    drive_idle();
    #2 rst_ni = 1'b1;
    step();
  endtask

  task automatic test_lw_wait();
    int st;
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 3, 32'hDEAD_BEEF, 2'd0, st);
    checks++;
    if (st != 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 3", st); end
    checks++;
    if (data_wb_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_data: got %h want deadbeef", data_wb_o);
    end
  endtask

  task automatic test_lb();
    int st;
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 1, 32'h80FF_FFFF, 2'd0, st);
    checks++;
    if (data_wb_o !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_sign: got %h want ffffff80", data_wb_o);
    end
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 0, 32'h80FF_FFFF, 2'd0, st);
    checks++;
    if (data_wb_o !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_zero: got %h want 00000080", data_wb_o);
    end
  endtask

  task automatic test_sh();
    int st;
    do_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 1'b0, 0, 32'h0, 2'd1, st);
    checks++;
    if (st != 0) begin errors++; $display("FAIL sh_zero_wait_stall: got %0d want 0", st); end
  endtask

  task automatic test_misalign();
    set_load(32'h101, 3'b010, 1'b0);
    dmem_ready_i = 1'b1; enable_i = 1'b0;
    #3;
    checks++;
    if ({dmem_valid_o, stall_o, misalign_o} !== 3'b000) begin
      errors++; $display("FAIL misalign_held: got v/st/mis=%b want 000", {dmem_valid_o, stall_o, misalign_o});
    end
    step();
    enable_i = 1'b1;
    #3;
    checks++;
    if ({dmem_valid_o, stall_o, misalign_o} !== 3'b001) begin
      errors++; $display("FAIL misalign_pulse: got v/st/mis=%b want 001", {dmem_valid_o, stall_o, misalign_o});
    end
    step();
    checks++;
    if (RegWEn_wb_o !== 1'b0) begin
      errors++; $display("FAIL misalign_regwen: got %b want 0", RegWEn_wb_o);
    end
    drive_idle();
    #3;
    checks++;
    if (misalign_o !== 1'b0) begin
      errors++; $display("FAIL misalign_one_pulse: got %b want 0", misalign_o);
    end
    step();
  endtask

  task automatic test_hold();
    drive_idle();
    alu_mem_i = 32'hA5A5_A5A5; WBSel_mem_i = 2'd1;
    step();
    set_load(32'h300, 3'b010, 1'b0);
    enable_i = 1'b0; dmem_ready_i = 1'b1; dmem_rdata_i = 32'h1122_3344;
    #3;
    checks++;
    if ({dmem_valid_o, stall_o} !== 2'b10) begin
      errors++; $display("FAIL hold_first_req: got v/st=%b want 10", {dmem_valid_o, stall_o});
    end
    step();
    dmem_rdata_i = 32'h5566_7788;
    for (int i = 0; i < 2; i++) begin
      enable_i = (i == 1);
      #3;
      checks++;
      if ({dmem_valid_o, aes_valid_o, stall_o} !== 3'b000) begin
        errors++; $display("FAIL hold_no_reissue i=%0d: got v/a/st=%b want 000", i,
                           {dmem_valid_o, aes_valid_o, stall_o});
      end
      if (i == 0) begin
        checks++;
        if (data_wb_o !== 32'hA5A5_A5A5) begin
          errors++; $display("FAIL hold_wb_frozen: got %h want a5a5a5a5", data_wb_o);
        end
      end
      step();
    end
    checks++;
    if (data_wb_o !== 32'h1122_3344) begin
      errors++; $display("FAIL hold_captured_data: got %h want 11223344", data_wb_o);
    end
    drive_idle();
  endtask

  task automatic test_flush();
    drive_idle();
    WBSel_mem_i = 2'd2; pc4_mem_i = 32'h0000_1234; RegWEn_mem_i = 1'b1;
    rsW_mem_i = 5'd9; inst_mem_i = 32'h0000_0013;
    step();
    enable_i = 1'b0; reset_i = 1'b1;
    step();
    checks++;
    if ({data_wb_o, RegWEn_wb_o} !== {32'h0000_1234, 1'b1}) begin
      errors++; $display("FAIL flush_needs_enable: got %h/%b want 00001234/1", data_wb_o, RegWEn_wb_o);
    end
    enable_i = 1'b1;
    step();
    checks++;
    if ({data_wb_o, RegWEn_wb_o, rsW_wb_o, inst_wb_o, csr_we_wb_o, csr_waddr_wb_o} !== '0) begin
      errors++; $display("FAIL flush_zero: got wb=%h rd=%0d inst=%h", data_wb_o, rsW_wb_o, inst_wb_o);
    end
    drive_idle();
  endtask

  task automatic test_aes();
    int st;
    do_access(1'b0, 3'b010, 32'h4000_0010, 32'h0, 1'b1, 1, 32'hCAFE_F00D, 2'd0, st);
    checks++;
    if (st != 1) begin errors++; $display("FAIL aes_stall_cycles: got %0d want 1", st); end
  endtask

  task automatic test_reset_busy();
    int st;
    set_load(32'h4000_0020, 3'b010, 1'b1);
    aes_ready_i = 1'b0; dmem_ready_i = 1'b0; enable_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      checks++;
      if ({aes_valid_o, dmem_valid_o, stall_o} !== 3'b101) begin
        errors++; $display("FAIL busy_before_reset i=%0d: got a/v/st=%b want 101", i,
                           {aes_valid_o, dmem_valid_o, stall_o});
      end
      step();
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_in_busy: got %h want 0", all_outs);
    end
    step();
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_in_busy_held: got %h want 0", all_outs);
    end
    drive_idle();
    #2 rst_ni = 1'b1;
    step();
    do_access(1'b0, 3'b010, 32'h4000_0024, 32'h0, 1'b1, 0, 32'h0BAD_F00D, 2'd0, st);
    checks++;
    if (st != 0) begin errors++; $display("FAIL idle_after_reset_stall: got %0d want 0", st); end
  endtask

  task automatic test_random();
    int st, lat;
    bit store, aes;
    logic [2:0] f3;
    logic [1:0] wbsel;
    logic [31:0] addr;
    logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 60; n++) begin
      store = 1'($urandom());
      aes   = 1'($urandom());
      f3    = store ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
      addr  = $urandom();
      lat   = $urandom_range(0, 3);
      wbsel = store ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      do_access(store, f3, addr, $urandom(), aes, lat, $urandom(), wbsel, st);
      checks++;
      if (st != (f_misaligned(f3, addr) ? 0 : lat)) begin
        errors++; $display("FAIL random_stall_count n=%0d: got %0d want %0d", n, st,
                           f_misaligned(f3, addr) ? 0 : lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_lb();
    test_sh();
    test_misalign();
    test_hold();
    test_flush();
    test_aes();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
